// File: rtl/dtc_master_link.sv
// dtc_master_link
// Initiator end of the DTC slow-control link. A command is taken from the
// cmd_* handshake and sent MSB first on dtc_data: start bit, rw, addr,
// wdata (writes only) and an even-parity bit. The reply from the FEC then
// arrives on dtc_return: start bit, 32 data bits and an even-parity bit.
// The reply is returned as a one-cycle rsp_valid strobe. If no reply start
// bit arrives within TIMEOUT_CYC cycles, the command ends with a timeout.
//
// Ports
//   dtc_clk     link bit clock, one serial bit per cycle
//   rst_n       synchronous active-low reset
//   cmd_valid   command request
//   cmd_ready   high only while idle
//   cmd_write   1 = write, 0 = read
//   cmd_addr    register address (ADDR_W bits)
//   cmd_wdata   write data, unused for reads
//   rsp_valid   one-cycle reply strobe
//   rsp_data    read value or echoed write data, held until the next reply
//   rsp_err     00 ok, 01 timeout, 10 reply parity error
//   busy        high whenever a command is in flight
//   err_cnt     saturating count of replies with rsp_err != 00
//   dtc_data    serial command line to the FEC, 0 when no frame bit is sent
//   dtc_return  serial reply line from the FEC (asynchronous)
module dtc_master_link #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              dtc_clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic [15:0]       err_cnt,
  output logic              dtc_data,
  input  logic              dtc_return
);

  // Bits that follow the start bit in a write frame: rw + addr + data + parity.
  localparam int SH_W  = ADDR_W + 34;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam int TC_W  = $clog2(TIMEOUT_CYC + 1);

  // The start bit goes out at acceptance, so the counter holds the bits left after it.
  localparam logic [CNT_W-1:0] CNT_WR = CNT_W'(SH_W);
  localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(ADDR_W + 2);
  localparam logic [TC_W-1:0]  TC_MAX = TC_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  state_t            state_reg, state_next;
  logic              ready_reg, ready_next;
  logic [SH_W-1:0]   sh_reg, sh_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [TC_W-1:0]   tcnt_reg, tcnt_next;
  logic [31:0]       rx_reg, rx_next;
  logic [5:0]        rcnt_reg, rcnt_next;
  logic [31:0]       rsp_data_reg, rsp_data_next;
  logic [1:0]        rsp_err_reg, rsp_err_next;
  logic [15:0]       err_cnt_reg, err_cnt_next;
  logic              dtc_data_reg, dtc_data_next;
  logic [1:0]        sync_reg;
  logic              ret_s;
  logic              bump;

  // Two-flop synchroniser: a pin value in cycle c is visible to the FSM in cycle c+2.
  assign ret_s = sync_reg[1];

  always_ff @(posedge dtc_clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ready_reg    <= 1'b0;
      sh_reg       <= '0;
      bit_cnt_reg  <= '0;
      tcnt_reg     <= '0;
      rx_reg       <= '0;
      rcnt_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 2'b00;
      err_cnt_reg  <= '0;
      dtc_data_reg <= 1'b0;
      sync_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      ready_reg    <= ready_next;
      sh_reg       <= sh_next;
      bit_cnt_reg  <= bit_cnt_next;
      tcnt_reg     <= tcnt_next;
      rx_reg       <= rx_next;
      rcnt_reg     <= rcnt_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
      err_cnt_reg  <= err_cnt_next;
      dtc_data_reg <= dtc_data_next;
      sync_reg     <= {sync_reg[0], dtc_return};
    end
  end

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    bit_cnt_next  = bit_cnt_reg;
    tcnt_next     = tcnt_reg;
    rx_next       = rx_reg;
    rcnt_next     = rcnt_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    err_cnt_next  = err_cnt_reg;
    dtc_data_next = 1'b0;
    bump          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && ready_reg) begin
          state_next    = SEND;
          dtc_data_next = 1'b1;
          if (cmd_write) begin
            bit_cnt_next = CNT_WR;
            sh_next      = {1'b1, cmd_addr, cmd_wdata, ^{1'b1, cmd_addr, cmd_wdata}};
          end else begin
            // Read frames are shorter; the unused tail is never shifted out.
            bit_cnt_next = CNT_RD;
            sh_next      = {1'b0, cmd_addr, ^cmd_addr, 32'h0};
          end
        end
      end
      SEND: begin
        if (bit_cnt_reg != '0) begin
          dtc_data_next = sh_reg[SH_W-1];
          sh_next       = {sh_reg[SH_W-2:0], 1'b0};
          bit_cnt_next  = bit_cnt_reg - CNT_W'(1);
        end else begin
          state_next = WAIT;
          tcnt_next  = '0;
        end
      end
      WAIT: begin
        // A start bit wins over an expiring counter in the same cycle.
        if (ret_s) begin
          state_next = RECV;
          rcnt_next  = '0;
        end else if (tcnt_reg == TC_MAX) begin
          state_next    = DONE;
          rsp_data_next = '0;
          rsp_err_next  = 2'b01;
          bump          = 1'b1;
        end else begin
          tcnt_next = tcnt_reg + TC_W'(1);
        end
      end
      RECV: begin
        if (rcnt_reg == 6'd32) begin
          // ret_s is the parity bit here; the reply is good when total parity is even.
          state_next    = DONE;
          rsp_data_next = rx_reg;
          rsp_err_next  = (^{rx_reg, ret_s}) ? 2'b10 : 2'b00;
          bump          = ^{rx_reg, ret_s};
        end else begin
          rx_next   = {rx_reg[30:0], ret_s};
          rcnt_next = rcnt_reg + 6'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (bump && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_next = err_cnt_reg + 16'd1;
    end
  end

  // Registered so that cmd_ready stays low while reset is held.
  assign ready_next = (state_next == IDLE);

  assign cmd_ready = ready_reg;
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign err_cnt   = err_cnt_reg;
  assign dtc_data  = dtc_data_reg;

endmodule

// File: tb/tb_dtc_master_link.sv
// Bench for dtc_master_link. It runs a linear sequence of directed and random
// commands. The expected frames, replies and error counts come from a
// bit-queue model of the link protocol.
module tb_dtc_master_link;
  localparam int ADDR_W = 16;
  localparam int TMO    = 16;

  logic        dtc_clk    = 1'b0;
  logic        rst_n      = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic        cmd_write  = 1'b0;
  logic [15:0] cmd_addr   = '0;
  logic [31:0] cmd_wdata  = '0;
  logic        dtc_return = 1'b0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [15:0] err_cnt;
  logic        dtc_data;

  int checks = 0;
  int errors = 0;
  int model_err_cnt = 0;

  dtc_master_link #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .dtc_clk(dtc_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .err_cnt(err_cnt), .dtc_data(dtc_data), .dtc_return(dtc_return)
  );

  always #5 dtc_clk = ~dtc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=expired required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge dtc_clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones32(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // Command frame as a bit list: start, rw, addr, [data], even parity excluding start.
  function automatic logic [63:0] build_frame(input bit w, input logic [15:0] a,
                                              input logic [31:0] d, output int len);
    bit q[$];
    int ones;
    logic [63:0] v;
    q.push_back(1'b1);
    q.push_back(w);
    for (int i = 15; i >= 0; i--) q.push_back(a[i]);
    if (w) for (int i = 31; i >= 0; i--) q.push_back(d[i]);
    ones = 0;
    for (int i = 1; i < q.size(); i++) ones += int'(q[i]);
    q.push_back(bit'(ones % 2));
    v = '0;
    foreach (q[i]) v = {v[62:0], q[i]};
    len = q.size();
    return v;
  endfunction

  // mode: 0 good reply, 1 reply with wrong parity, 2 no reply (timeout)
  task automatic run_cmd(input string tag, input bit w, input logic [15:0] a,
                         input logic [31:0] d, input int mode,
                         input logic [31:0] rdata, input int delay);
    logic [63:0] frame_exp;
    logic [63:0] frame_got;
    int          len;
    int          n;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    bit          pbit;

    frame_exp = build_frame(w, a, d, len);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin step(); n++; end
    check({tag, "_ready"}, 64'(cmd_ready), 64'd1);

    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    step();
    // Scramble the inputs; they must not be sampled while busy.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = $urandom;

    frame_got = '0;
    for (int i = 0; i < len; i++) begin
      frame_got = {frame_got[62:0], dtc_data};
      if (i < len - 1) step();
    end
    check({tag, "_frame"}, frame_got, frame_exp);

    step();
    check({tag, "_line_idle"}, 64'(dtc_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd1);

    if (mode == 2) begin
      n = 1;
      while (rsp_valid !== 1'b1 && n < TMO + 20) begin step(); n++; end
      check({tag, "_tmo_lat"}, 64'(n), 64'(TMO + 2));
      exp_data = '0;
      exp_err  = 2'b01;
    end else begin
      for (int i = 0; i < delay; i++) step();
      dtc_return = 1'b1;
      step();
      for (int i = 31; i >= 0; i--) begin
        dtc_return = rdata[i];
        step();
      end
      pbit = bit'(ones32(rdata) % 2);
      if (mode == 1) pbit = !pbit;
      dtc_return = pbit;
      step();
      dtc_return = 1'b0;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 12) begin step(); n++; end
      check({tag, "_rsp_lat"}, 64'(n), 64'd3);
      exp_data = rdata;
      exp_err  = (mode == 1) ? 2'b10 : 2'b00;
    end

    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
    if (exp_err != 2'b00 && model_err_cnt < 65535) model_err_cnt++;
    step();
    check({tag, "_strobe_once"}, 64'(rsp_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(model_err_cnt));
  endtask

  initial begin
    int n;
    int pulses;
    int line_ones;
    logic [31:0] rd;
    int mode;
    bit w;

    // Reset state
    step(); step(); step();
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dtc_data", 64'(dtc_data), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    step();
    check("rel_ready", 64'(cmd_ready), 64'd1);

    // Directed cases
    run_cmd("wr_echo", 1'b1, 16'h0004, 32'h0000003F, 0, 32'h0000003F, 2);
    run_cmd("rd_good", 1'b0, 16'h0010, 32'h0, 0, 32'h12345678, 0);
    run_cmd("rd_badpar", 1'b0, 16'h0010, 32'h0, 1, 32'h12345678, 5);
    run_cmd("rd_tmo", 1'b0, 16'h0020, 32'h0, 2, 32'h0, 0);

    // Random commands and replies
    for (int t = 0; t < 24; t++) begin
      w    = 1'($urandom);
      rd   = $urandom;
      mode = $urandom_range(0, 2);
      run_cmd($sformatf("rnd%0d", t), w, 16'($urandom), $urandom, mode, rd,
              $urandom_range(0, 10));
    end

    // Reset asserted in the middle of a write frame
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h5A5A; cmd_wdata = 32'hFFFF_FFFF;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i < 20; i++) step();
    rst_n = 1'b0;
    step();
    check("midrst_dtc_data", 64'(dtc_data), 64'd0);
    check("midrst_ready", 64'(cmd_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();
    model_err_cnt = 0;
    check("midrst_ready_rel", 64'(cmd_ready), 64'd1);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    pulses = 0; line_ones = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1) pulses++;
      if (dtc_data === 1'b1) line_ones++;
      step();
    end
    check("midrst_no_rsp", 64'(pulses), 64'd0);
    check("midrst_line_quiet", 64'(line_ones), 64'd0);
    run_cmd("post_rst_rd", 1'b0, 16'h0033, 32'h0, 0, 32'hCAFE_F00D, 3);

    // Saturation and back-to-back accepts with cmd_valid held high
    force dut.err_cnt_reg = 16'hFFFD;
    step();
    release dut.err_cnt_reg;
    model_err_cnt = 16'hFFFD;
    step();
    check("sat_preload", 64'(err_cnt), 64'(model_err_cnt));
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0ABC;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
      check($sformatf("b2b%0d_rsp", t), 64'(rsp_valid), 64'd1);
      check($sformatf("b2b%0d_err", t), 64'(rsp_err), 64'd1);
      if (model_err_cnt < 65535) model_err_cnt++;
      step();
      check($sformatf("b2b%0d_ready", t), 64'(cmd_ready), 64'd1);
      check($sformatf("b2b%0d_gap", t), 64'(dtc_data), 64'd0);
      check($sformatf("b2b%0d_err_cnt", t), 64'(err_cnt), 64'(model_err_cnt));
      step();
      check($sformatf("b2b%0d_start", t), 64'(dtc_data), 64'd1);
    end
    cmd_valid = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
    step();
    check("sat_final", 64'(err_cnt), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
